// File: rtl/seg7_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder_if
// Bundles the multiplexed 7-segment bus, the error-clear strobe and the
// decoded results of seg7_scan_decoder.
//   master : drives the bus (iSEG, iAN, iCLR_ERR[, iDP]) and reads the results
//   slave  : the decoder; reads the bus and drives oDIG, oVALID, oUPD, oERR[, oDP]
// Optional feature macro: SEG7_SCAN_DP_EN adds iDP / oDP (decimal point).
// -----------------------------------------------------------------------------
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              iSEG;      // segment lines, active-low
    logic [NUM_DIGITS-1:0]   iAN;       // digit enables, active-low
    logic                    iCLR_ERR;  // synchronous clear of oERR
    logic [4*NUM_DIGITS-1:0] oDIG;      // captured hex value per digit
    logic [NUM_DIGITS-1:0]   oVALID;    // last capture of that digit was legal
    logic                    oUPD;      // one-cycle pulse per legal capture
    logic                    oERR;      // sticky error flag
`ifdef SEG7_SCAN_DP_EN
    logic                    iDP;       // decimal point, active-low
    logic [NUM_DIGITS-1:0]   oDP;       // captured decimal point, active-high

    modport master (output iSEG, iAN, iCLR_ERR, iDP,
                    input  oDIG, oVALID, oUPD, oERR, oDP);
    modport slave  (input  iSEG, iAN, iCLR_ERR, iDP,
                    output oDIG, oVALID, oUPD, oERR, oDP);
`else
    modport master (output iSEG, iAN, iCLR_ERR,
                    input  oDIG, oVALID, oUPD, oERR);
    modport slave  (input  iSEG, iAN, iCLR_ERR,
                    output oDIG, oVALID, oUPD, oERR);
`endif
endinterface

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Watches a time-multiplexed 7-segment bus, waits until the synchronized bus
// has been steady long enough, then decodes the selected digit's segment
// pattern back to a hex nibble. Illegal patterns and multi-digit selects set
// a sticky error flag.
// Ports:
//   iCLK    system clock
//   iRST_N  asynchronous active-low reset (release assumed synchronous)
//   bus     seg7_scan_decoder_if.slave: iSEG, iAN, iCLR_ERR in;
//           oDIG, oVALID, oUPD, oERR out (all registered)
// Parameters: NUM_DIGITS (1..8), STABLE_CYCLES (2..255)
// Optional feature macro: SEG7_SCAN_DP_EN (decimal point iDP/oDP).
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    seg7_scan_decoder_if.slave bus
);
`ifdef SEG7_SCAN_DP_EN
    localparam int SAMP_W = NUM_DIGITS + 8;
`else
    localparam int SAMP_W = NUM_DIGITS + 7;
`endif
    localparam logic [7:0]        CNT_MAX   = 8'(STABLE_CYCLES - 1);
    localparam logic [SAMP_W-1:0] SAMP_IDLE = {SAMP_W{1'b1}};

    // Returns {legal, hex}; the all-off pattern is a legal F.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: seg_decode = {1'b1, 4'h0};
            7'b1111001: seg_decode = {1'b1, 4'h1};
            7'b0100100: seg_decode = {1'b1, 4'h2};
            7'b0110000: seg_decode = {1'b1, 4'h3};
            7'b0011001: seg_decode = {1'b1, 4'h4};
            7'b0010010: seg_decode = {1'b1, 4'h5};
            7'b0000010: seg_decode = {1'b1, 4'h6};
            7'b1111000: seg_decode = {1'b1, 4'h7};
            7'b0000000: seg_decode = {1'b1, 4'h8};
            7'b0011000: seg_decode = {1'b1, 4'h9};
            7'b0001000: seg_decode = {1'b1, 4'hA};
            7'b0000011: seg_decode = {1'b1, 4'hB};
            7'b1000110: seg_decode = {1'b1, 4'hC};
            7'b0100001: seg_decode = {1'b1, 4'hD};
            7'b0000110: seg_decode = {1'b1, 4'hE};
            7'b1111111: seg_decode = {1'b1, 4'hF};
            default:    seg_decode = {1'b0, 4'h0};
        endcase
    endfunction

    logic [SAMP_W-1:0]       samp_s;
    logic [SAMP_W-1:0]       s1_r, s2_r, s3_r;
    logic [7:0]              cnt_r;
    logic                    captured_r;
    logic                    stable_s, capture_s;
    logic [NUM_DIGITS-1:0]   an_s;
    logic [6:0]              seg_s;
    logic [4:0]              dec_s;
    logic [3:0]              zero_cnt_s;
    logic [2:0]              sel_idx_s;
    logic                    err_set_s;
    logic [4*NUM_DIGITS-1:0] dig_r, dig_nxt_s;
    logic [NUM_DIGITS-1:0]   valid_r, valid_nxt_s;
    logic                    upd_r, upd_nxt_s;
    logic                    err_r, err_nxt_s;
`ifdef SEG7_SCAN_DP_EN
    logic                    dp_s;
    logic [NUM_DIGITS-1:0]   dp_r, dp_nxt_s;

    assign samp_s = {bus.iDP, bus.iSEG, bus.iAN};
    assign dp_s   = s2_r[SAMP_W-1];
    assign bus.oDP = dp_r;
`else
    assign samp_s = {bus.iSEG, bus.iAN};
`endif

    assign an_s      = s2_r[NUM_DIGITS-1:0];
    assign seg_s     = s2_r[NUM_DIGITS+6:NUM_DIGITS];
    assign dec_s     = seg_decode(seg_s);
    assign stable_s  = (s2_r == s3_r);
    // Requiring the current compare too keeps a sample that changed on this
    // very edge from being captured with a stale count.
    assign capture_s = stable_s && (cnt_r == CNT_MAX) && !captured_r;

    assign bus.oDIG   = dig_r;
    assign bus.oVALID = valid_r;
    assign bus.oUPD   = upd_r;
    assign bus.oERR   = err_r;

    // Two-flop synchronizer plus previous-sample register; idle is all ones.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s1_r <= SAMP_IDLE;
            s2_r <= SAMP_IDLE;
            s3_r <= SAMP_IDLE;
        end else begin
            s1_r <= samp_s;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Saturating stability counter; captured allows one capture per steady run.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_r      <= 8'd0;
            captured_r <= 1'b0;
        end else if (!stable_s) begin
            cnt_r      <= 8'd0;
            captured_r <= 1'b0;
        end else begin
            if (cnt_r != CNT_MAX) cnt_r <= cnt_r + 8'd1;
            else                  cnt_r <= cnt_r;
            if (capture_s) captured_r <= 1'b1;
            else           captured_r <= captured_r;
        end
    end

    // Count the low enables and remember the (only meaningful if single) index.
    always_comb begin
        zero_cnt_s = 4'd0;
        sel_idx_s  = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) begin
                zero_cnt_s = zero_cnt_s + 4'd1;
                sel_idx_s  = 3'(i);
            end else begin
                zero_cnt_s = zero_cnt_s;
                sel_idx_s  = sel_idx_s;
            end
        end
    end

    // Next-state of the result registers for the capture action.
    always_comb begin
        dig_nxt_s   = dig_r;
        valid_nxt_s = valid_r;
        upd_nxt_s   = 1'b0;
        err_set_s   = 1'b0;
`ifdef SEG7_SCAN_DP_EN
        dp_nxt_s    = dp_r;
`endif
        if (capture_s) begin
            if (zero_cnt_s == 4'd0) begin
                err_set_s = 1'b0;            // blank interval between digits
            end else if (zero_cnt_s != 4'd1) begin
                err_set_s = 1'b1;            // several digits enabled at once
            end else if (dec_s[4]) begin
                upd_nxt_s = 1'b1;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_idx_s == 3'(i)) begin
                        dig_nxt_s[4*i +: 4] = dec_s[3:0];
                        valid_nxt_s[i]      = 1'b1;
`ifdef SEG7_SCAN_DP_EN
                        dp_nxt_s[i]         = ~dp_s;
`endif
                    end else begin
                        dig_nxt_s[4*i +: 4] = dig_r[4*i +: 4];
                    end
                end
            end else begin
                err_set_s = 1'b1;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_idx_s == 3'(i)) valid_nxt_s[i] = 1'b0;
                    else                    valid_nxt_s[i] = valid_r[i];
                end
            end
        end else begin
            upd_nxt_s = 1'b0;
        end
        // A new error on the same edge as a clear keeps the flag set.
        if (err_set_s)         err_nxt_s = 1'b1;
        else if (bus.iCLR_ERR) err_nxt_s = 1'b0;
        else                   err_nxt_s = err_r;
    end

    // Result registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            dig_r   <= '0;
            valid_r <= '0;
            upd_r   <= 1'b0;
            err_r   <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            dp_r    <= '0;
`endif
        end else begin
            dig_r   <= dig_nxt_s;
            valid_r <= valid_nxt_s;
            upd_r   <= upd_nxt_s;
            err_r   <= err_nxt_s;
`ifdef SEG7_SCAN_DP_EN
            dp_r    <= dp_nxt_s;
`endif
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Table-driven directed vectors, hand-written sequences for error-clear
// collision and mid-run reset, and a randomized phase checked every cycle
// against a behavioural model built on a delayed-sample run-length view.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;
    localparam int ND = 4;
    localparam int SC = 4;
    localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};

    logic iCLK   = 1'b0;
    logic iRST_N = 1'b1;
    seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus_if ();
    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .bus   (bus_if)
    );

    // Free-running clock.
    always #5 iCLK = ~iCLK;

    int checks   = 0;
    int failures = 0;
    bit mon_on   = 1'b0;

    // Behavioural model: the decoder sees the input two edges late and acts
    // when a run of identical delayed samples first reaches SC+1.
    logic [10:0] mq[$];
    logic [10:0] last_v;
    int          runlen;
    logic [15:0] m_dig;
    logic [3:0]  m_valid;
    logic        m_upd, m_err;

    task automatic model_reset();
        mq = {11'h7FF, 11'h7FF};
        last_v  = 11'h7FF;
        runlen  = 1;
        m_dig   = 16'h0;
        m_valid = 4'h0;
        m_upd   = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input logic [6:0] seg, input logic [3:0] an, input logic clr);
        logic [10:0] v;
        bit set_e;
        int nz, d, hv;
        mq.push_back({seg, an});
        v = mq.pop_front();
        if (v == last_v) begin
            if (runlen < 1000) runlen++;
        end else begin
            runlen = 1;
        end
        last_v = v;
        m_upd  = 1'b0;
        set_e  = 1'b0;
        if (runlen == SC + 1) begin
            nz = 0; d = 0;
            for (int i = 0; i < ND; i++) if (!v[i]) begin nz++; d = i; end
            if (nz > 1) begin
                set_e = 1'b1;
            end else if (nz == 1) begin
                hv = -1;
                for (int k = 0; k < 16; k++) if (PAT[k] == v[10:4]) hv = k;
                if (hv >= 0) begin
                    m_dig[4*d +: 4] = 4'(hv);
                    m_valid[d] = 1'b1;
                    m_upd = 1'b1;
                end else begin
                    m_valid[d] = 1'b0;
                    set_e = 1'b1;
                end
            end
        end
        if (set_e)    m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    // Advance the model on each clock edge, reset it on reset assertion.
    initial begin
        model_reset();
        forever begin
            @(posedge iCLK or negedge iRST_N);
            if (!iRST_N) model_reset();
            else model_step(bus_if.iSEG, bus_if.iAN, bus_if.iCLR_ERR);
        end
    end

    // Compare DUT against the model every falling edge.
    initial begin
        forever begin
            @(negedge iCLK);
            if (mon_on) begin
                checks++;
                if (bus_if.oDIG !== m_dig || bus_if.oVALID !== m_valid ||
                    bus_if.oUPD !== m_upd || bus_if.oERR !== m_err) begin
                    failures++;
                    $display("FAIL model_cycle t=%0t dig=%h/%h valid=%b/%b upd=%b/%b err=%b/%b (actual/required)",
                             $time, bus_if.oDIG, m_dig, bus_if.oVALID, m_valid,
                             bus_if.oUPD, m_upd, bus_if.oERR, m_err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    int upd_n, upd_at;

    // Called at a falling edge: drive inputs and hold them for n edges.
    task automatic run(input logic [3:0] an, input logic [6:0] seg, input logic clr, input int n);
        bus_if.iAN      = an;
        bus_if.iSEG     = seg;
        bus_if.iCLR_ERR = clr;
`ifdef SEG7_SCAN_DP_EN
        bus_if.iDP      = 1'b1;
`endif
        upd_n  = 0;
        upd_at = 0;
        for (int e = 1; e <= n; e++) begin
            @(negedge iCLK);
            if (bus_if.oUPD) begin upd_n++; upd_at = e; end
        end
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        clr;
        int          hold;
        logic [15:0] dig;
        logic [3:0]  valid;
        logic        err;
        int          updn;
        int          updat;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic [3:0] an_r;
        logic [6:0] seg_r;
        int hold, a, b;

        vt[0]  = '{4'b1110, 7'h24, 1'b0, 10, 16'h0002, 4'b0001, 1'b0, 1, 7};
        vt[1]  = '{4'b1011, 7'h30, 1'b0, 3,  16'h0002, 4'b0001, 1'b0, 0, 0};
        vt[2]  = '{4'b1011, 7'h19, 1'b0, 8,  16'h0402, 4'b0101, 1'b0, 1, 7};
        vt[3]  = '{4'b1101, 7'h55, 1'b0, 8,  16'h0402, 4'b0101, 1'b1, 0, 0};
        vt[4]  = '{4'b1100, 7'h40, 1'b0, 8,  16'h0402, 4'b0101, 1'b1, 0, 0};
        vt[5]  = '{4'b1111, 7'h7F, 1'b1, 2,  16'h0402, 4'b0101, 1'b0, 0, 0};
        vt[6]  = '{4'b1111, 7'h40, 1'b0, 8,  16'h0402, 4'b0101, 1'b0, 0, 0};
        vt[7]  = '{4'b1110, 7'h7F, 1'b0, 6,  16'h0402, 4'b0101, 1'b0, 0, 0};
        vt[8]  = '{4'b1101, 7'h40, 1'b0, 6,  16'h040F, 4'b0101, 1'b0, 1, 1};
        vt[9]  = '{4'b1011, 7'h08, 1'b0, 6,  16'h040F, 4'b0111, 1'b0, 1, 1};
        vt[10] = '{4'b0111, 7'h21, 1'b0, 6,  16'h0A0F, 4'b0111, 1'b0, 1, 1};
        vt[11] = '{4'b1111, 7'h7F, 1'b0, 8,  16'hDA0F, 4'b1111, 1'b0, 1, 1};

        bus_if.iAN = 4'hF; bus_if.iSEG = 7'h7F; bus_if.iCLR_ERR = 1'b0;
`ifdef SEG7_SCAN_DP_EN
        bus_if.iDP = 1'b1;
`endif
        #3 iRST_N = 1'b0;
        #1 mon_on = 1'b1;
        repeat (3) @(negedge iCLK);
        chk("reset_dig",   32'(bus_if.oDIG),   32'h0);
        chk("reset_valid", 32'(bus_if.oVALID), 32'h0);
        chk("reset_upd",   32'(bus_if.oUPD),   32'h0);
        chk("reset_err",   32'(bus_if.oERR),   32'h0);
        #2 iRST_N = 1'b1;
        @(negedge iCLK);

        for (int i = 0; i < 12; i++) begin
            run(vt[i].an, vt[i].seg, vt[i].clr, vt[i].hold);
            chk($sformatf("vec%0d_dig", i),    32'(bus_if.oDIG),   32'(vt[i].dig));
            chk($sformatf("vec%0d_valid", i),  32'(bus_if.oVALID), 32'(vt[i].valid));
            chk($sformatf("vec%0d_err", i),    32'(bus_if.oERR),   32'(vt[i].err));
            chk($sformatf("vec%0d_upd_n", i),  32'(upd_n),         32'(vt[i].updn));
            chk($sformatf("vec%0d_upd_at", i), 32'(upd_at),        32'(vt[i].updat));
        end

        // Error capture and clear on the same edge: the set must win.
        run(4'b1101, 7'h2A, 1'b0, 6);
        run(4'b1101, 7'h2A, 1'b1, 1);
        chk("clr_collide_err",   32'(bus_if.oERR),   32'h1);
        chk("clr_collide_valid", 32'(bus_if.oVALID), 32'hD);
        chk("clr_collide_dig",   32'(bus_if.oDIG),   32'hDA0F);
        run(4'b1101, 7'h2A, 1'b0, 2);
        run(4'b1101, 7'h2A, 1'b1, 1);
        chk("clr_alone_err", 32'(bus_if.oERR), 32'h0);

        // Reset while the counter is at 2 in a steady run.
        run(4'b1110, 7'h79, 1'b0, 5);
        #2 iRST_N = 1'b0;
        #1;
        chk("midrst_dig",   32'(bus_if.oDIG),   32'h0);
        chk("midrst_valid", 32'(bus_if.oVALID), 32'h0);
        chk("midrst_err",   32'(bus_if.oERR),   32'h0);
        repeat (2) @(negedge iCLK);
        #2 iRST_N = 1'b1;
        run(4'b1110, 7'h79, 1'b0, 8);
        chk("midrst_upd_at", 32'(upd_at),         32'd7);
        chk("midrst_upd_n",  32'(upd_n),          32'd1);
        chk("midrst_dig1",   32'(bus_if.oDIG),    32'h0001);
        chk("midrst_valid1", 32'(bus_if.oVALID),  32'h1);

        // Randomized phase; the monitor compares every cycle.
        run(4'hF, 7'h7F, 1'b0, 10);
        for (int t = 0; t < 300; t++) begin
            a = $urandom_range(0, 9);
            if (a == 0) begin
                an_r = 4'hF;
            end else if (a == 1) begin
                a = $urandom_range(0, 3);
                b = (a + 1 + $urandom_range(0, 2)) % 4;
                an_r = 4'hF;
                an_r[a] = 1'b0;
                an_r[b] = 1'b0;
            end else begin
                an_r = 4'hF;
                an_r[$urandom_range(0, 3)] = 1'b0;
            end
            if ($urandom_range(0, 9) < 7) seg_r = PAT[$urandom_range(0, 15)];
            else                          seg_r = 7'($urandom_range(0, 127));
            hold = $urandom_range(1, 9);
            for (int h = 0; h < hold; h++)
                run(an_r, seg_r, ($urandom_range(0, 7) == 0), 1);
        end
        run(4'hF, 7'h7F, 1'b0, 10);
        chk("rand_final_dig",   32'(bus_if.oDIG),   32'(m_dig));
        chk("rand_final_valid", 32'(bus_if.oVALID), 32'(m_valid));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-segment encoder.
- Watches a time-multiplexed 7-segment bus (shared segment lines plus per-digit enables), waits for the bus to settle, and decodes each digit's pattern back to a 4-bit hex value.
- Holds one captured value per digit and flags patterns that are not in the encode table.
- Used for self-check of display paths and for board-level readback of an external display driver.

Parameters:
- NUM_DIGITS, 4: digit enables on the bus; legal range 1..8.
- STABLE_CYCLES, 4: consecutive matching synchronized samples required before capture; legal range 2..255.

Ports:
- iCLK  input  1  system clock.
- iRST_N  input  1  asynchronous active-low reset.
- iSEG  input  7  segment lines, active-low; bit0=top, bit1=upper-right, bit2=lower-right, bit3=bottom, bit4=lower-left, bit5=upper-left, bit6=middle.
- iAN  input  NUM_DIGITS  digit enables, active-low; exactly one low bit selects a digit.
- iCLR_ERR  input  1  synchronous clear of oERR.
- oDIG  output  4*NUM_DIGITS  captured hex values; digit d occupies bits [4d+3:4d].
- oVALID  output  NUM_DIGITS  per-digit flag: last capture for that digit decoded legally.
- oUPD  output  1  one-cycle pulse on every legal capture.
- oERR  output  1  sticky error flag.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - oDIG=0, oVALID=0, oUPD=0, oERR=0.
  - Synchronizer stages and the previous-sample register load all ones (blank, no digit).
  - Stability counter=0, captured flag=0.
- Input path: {iSEG,iAN} pass through a 2-flop synchronizer (s1, s2). Register s3 holds the previous s2.
- Stability counter, each edge:
  - If s2 != s3: counter <= 0, captured <= 0.
  - Else: counter increments, saturating at STABLE_CYCLES-1.
  - s3 <= s2 every edge.
- Capture fires on the edge where counter == STABLE_CYCLES-1 and captured == 0; that edge sets captured <= 1.
  - At most one capture per stable period. A bus held indefinitely captures once.
- Latency: inputs that change before edge E0 and then hold produce a capture on edge E0+STABLE_CYCLES+2.
- Capture action, depends on iAN (taken from s2):
  - All ones (blank interval): no action.
  - More than one bit low: oERR <= 1; oDIG and oVALID unchanged.
  - Exactly one bit low, at index d:
    - Legal pattern: oDIG[d] <= decoded value, oVALID[d] <= 1, oUPD pulses high for exactly one cycle.
    - Illegal pattern: oDIG[d] unchanged, oVALID[d] <= 0, oERR <= 1, no oUPD.
- Decode table (pattern as 7-bit value bit6..bit0 -> hex):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3
  - 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 0000000->8, 0011000->9, 0001000->A, 0000011->B
  - 1000110->C, 0100001->D, 0000110->E, 1111111->F
  - All other 112 patterns are illegal.
  - The all-off pattern is defined as hex F and is legal.
- oERR: set on the error conditions above; cleared by iCLR_ERR. If set and clear occur on the same edge, set wins.
- Reset mid-stable-period: counter and captured return to 0 and outputs return to reset values. A capture must not complete during or on the edge after reset release.

Optional Feature:
- Macro: SEG7_SCAN_DP_EN.
- With it defined:
  - Extra input iDP (1 bit, active-low decimal point) is synchronized and compared alongside iSEG.
  - Extra output oDP (NUM_DIGITS bits, active-high) is reset to 0; on a legal capture, oDP[d] <= ~iDP.
  - iDP never causes an error.
- Without it: neither port exists, and the decimal point is not part of the stability compare.

Test Plan:
1. STABLE_CYCLES=4. iAN=4'b1110, iSEG=7'b0100100 held 10 cycles from before E0 -> at E6: oDIG[3:0]=4'h2, oVALID=4'b0001, oUPD high for one cycle only; no further oUPD while held.
2. iAN=4'b1011, iSEG=7'b0110000 held 3 cycles, then iSEG=7'b0011001 held 8 cycles -> no capture of 3; oDIG[11:8]=4'h4 captured exactly 6 edges after the change.
3. iAN=4'b1101, iSEG=7'b1010101 held 8 cycles -> oVALID[1]=0, oERR=1, oDIG[7:4] unchanged, no oUPD. Pulse iCLR_ERR while a new error capture occurs on the same edge -> oERR stays 1. Pulse iCLR_ERR alone -> oERR=0.
4. iAN=4'b1100 held 8 cycles -> oERR=1, oDIG/oVALID unchanged. iAN=4'b1111 held 8 cycles -> no change, no oERR.
5. Cycle digits 0..3 with 1111111, 1000000, 0001000, 0100001, each held 6 cycles -> oDIG=16'hDA0F, oVALID=4'hF, four oUPD pulses.
6. Assert iRST_N low at counter value 2 during a stable period, release, hold inputs -> all outputs 0 during reset; capture occurs 6 edges after the first post-reset edge, not earlier.
